// File: rtl/nibble_serial_alu_ctrl_if.sv
// CPU-side start/done bundle for the nibble-serial ALU sequencer.
// Operands in, result and flags out.
interface nibble_serial_alu_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int DW = 4 * NIBBLES;

  logic          start;
  logic          op_sub;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic          flag_c;
  logic          flag_z;
  logic          flag_n;
  logic          flag_v;

  modport master (
    output start, op_sub, op_a, op_b,
    input  busy, done, result,
    input  flag_c, flag_z, flag_n, flag_v
  );

  modport slave (
    input  start, op_sub, op_a, op_b,
    output busy, done, result,
    output flag_c, flag_z, flag_n, flag_v
  );
endinterface

// File: rtl/nibble_serial_alu_ctrl.sv
// Drives one external 4-bit adder over NIBBLES cycles to build a
// DATA_W-bit ADD/SUB result, LS nibble first, with C/Z/N/V flags.
module nibble_serial_alu_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_alu_ctrl_if.slave bus,
  output logic [3:0]           adder_a,
  output logic [3:0]           adder_b,
  output logic                 adder_cin,
  input  logic [3:0]           adder_s,
  input  logic                 adder_co
);
  localparam int DW = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] res_q, res_d;
  logic          c_q, c_d;
  logic          z_q, z_d;
  logic          n_q, n_d;
  logic          v_q, v_d;
  logic          last;

  assign last = (idx_q == IW'(NIBBLES - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    c_d       = c_q;
    z_d       = z_q;
    n_d       = n_q;
    v_d       = v_q;
    adder_a   = 4'h0;
    adder_b   = 4'h0;
    adder_cin = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.op_a;
          // SUB is A + ~B + 1: invert B and seed the carry
          b_d     = bus.op_sub ? ~bus.op_b : bus.op_b;
          carry_d = bus.op_sub;
          idx_d   = '0;
          res_d   = '0;
          c_d     = 1'b0;
          z_d     = 1'b0;
          n_d     = 1'b0;
          v_d     = 1'b0;
        end
      end
      RUN: begin
        adder_a   = a_q[4*idx_q +: 4];
        adder_b   = b_q[4*idx_q +: 4];
        adder_cin = carry_q;
        res_d[4*idx_q +: 4] = adder_s;
        carry_d   = adder_co;
        idx_d     = last ? '0 : idx_q + 1'b1;
        if (last) begin
          state_d = DONE;
          c_d     = adder_co;
          z_d     = (res_d == '0);
          n_d     = res_d[DW-1];
          v_d     = (a_q[DW-1] == b_q[DW-1]) &&
                    (res_d[DW-1] != a_q[DW-1]);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = res_q;
  assign bus.flag_c = c_q;
  assign bus.flag_z = z_q;
  assign bus.flag_n = n_q;
  assign bus.flag_v = v_q;
endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Bench for nibble_serial_alu_ctrl: 4-bit adder modelled inline,
// results checked against arithmetic reference of ADD/SUB.
module tb_nibble_serial_alu_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] adder_a;
  logic [3:0] adder_b;
  logic       adder_cin;
  logic [3:0] adder_s;
  logic       adder_co;

  int checks = 0;
  int errors = 0;

  nibble_serial_alu_ctrl_if #(.NIBBLES(4)) bus ();

  nibble_serial_alu_ctrl #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_cin (adder_cin),
    .adder_s   (adder_s),
    .adder_co  (adder_co)
  );

  assign {adder_co, adder_s} = {1'b0, adder_a} + {1'b0, adder_b}
                             + {4'b0, adder_cin};

  always #5 clk = ~clk;

  // {result, C, Z, N, V}
  function automatic logic [19:0] ref_op(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        sub
  );
    int ua, ub, us, sa, sb, ss;
    logic [15:0] r;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      us = ua - ub;
      ss = sa - sb;
      c  = (ua >= ub);
    end else begin
      us = ua + ub;
      ss = sa + sb;
      c  = (us > 65535);
    end
    r = 16'(us);
    v = (ss > 32767) || (ss < -32768);
    return {r, c, (r == 16'h0), r[15], v};
  endfunction

  function automatic logic [19:0] obs();
    return {bus.result, bus.flag_c, bus.flag_z,
            bus.flag_n, bus.flag_v};
  endfunction

  task automatic do_op(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        sub,
    input string       name
  );
    logic [19:0] exp;
    exp = ref_op(a, b, sub);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.op_sub = sub;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.op_a   = 16'($urandom);
    bus.op_b   = 16'($urandom);
    bus.op_sub = 1'($urandom);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      checks++;
      if ({bus.busy, bus.done} !== {k < 4, k == 4}) begin
        errors++;
        $display("FAIL %s timing k=%0d busy/done=%b%b exp %b%b",
                 name, k, bus.busy, bus.done, k < 4, k == 4);
      end
    end
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL %s result got %h cznv=%b exp %h cznv=%b",
               name, obs() >> 4, obs() & 20'hF,
               exp >> 4, exp & 20'hF);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || obs() !== exp) begin
      errors++;
      $display("FAIL %s hold got done=%b busy=%b val=%h exp val=%h",
               name, bus.done, bus.busy, obs(), exp);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op_sub = 1'b0;
    bus.op_a   = 16'h0;
    bus.op_b   = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, obs(), adder_a, adder_b, adder_cin}
        !== '0) begin
      errors++;
      $display("FAIL reset outputs busy=%b done=%b val=%h adder=%h%h%b",
               bus.busy, bus.done, obs(), adder_a, adder_b, adder_cin);
    end
  endtask

  task automatic test_directed();
    do_op(16'h1234, 16'h1111, 1'b0, "add_basic");
    do_op(16'hFFFF, 16'h0001, 1'b0, "add_ripple");
    do_op(16'h7FFF, 16'h0001, 1'b0, "add_ovf");
    do_op(16'h8000, 16'h0001, 1'b1, "sub_ovf");
    do_op(16'h0005, 16'h0007, 1'b1, "sub_borrow");
    do_op(16'h1234, 16'h1234, 1'b1, "sub_zero");
    checks++;
    if ({adder_a, adder_b, adder_cin} !== 9'h0) begin
      errors++;
      $display("FAIL idle_adder got %h%h%b exp 0",
               adder_a, adder_b, adder_cin);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 6 == 0) a = 16'h8000;
      if (i % 7 == 0) b = 16'hFFFF;
      do_op(a, b, 1'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    logic [19:0] exp;
    exp = ref_op(16'h1234, 16'h1111, 1'b0);
    dones = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_a   = 16'h1234;
    bus.op_b   = 16'h1111;
    bus.op_sub = 1'b0;
    @(posedge clk);
    #1;
    bus.op_a   = 16'h0F0F;
    bus.op_b   = 16'h7001;
    bus.op_sub = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    if (bus.done) dones++;
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL b2b_dones got %0d exp 1", dones);
    end
    checks++;
    if (obs() !== exp || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result got %h busy=%b exp %h busy=0",
               obs(), bus.busy, exp);
    end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    dones = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_a   = 16'hFFFF;
    bus.op_b   = 16'h0001;
    bus.op_sub = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, obs(), adder_a, adder_b, adder_cin}
        !== '0) begin
      errors++;
      $display("FAIL midrst outputs busy=%b done=%b val=%h exp 0",
               bus.busy, bus.done, obs());
    end
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL midrst_quiet got %0d active cycles exp 0", dones);
    end
    do_op(16'h0003, 16'h0004, 1'b0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
